// File: rtl/hazard_scheduler.sv
// rtl/hazard_scheduler.sv - E/M/W hazard tracking, D-stage forward selects, stall and mult/div busy counter
module hazard_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [1:0] rs_tuse_d,
    input  logic [1:0] rt_tuse_d,
    input  logic [4:0] dst_d,
    input  logic [1:0] src_d,
    input  logic       md_start_d,
    input  logic       md_div_d,
    input  logic       md_use_d,
    output logic       stop,
    output logic [2:0] rs_data_d_to_reg_type,
    output logic [2:0] rt_data_d_to_reg_type,
    output logic       md_busy
);

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_MEM = 2'd1;
    localparam logic [1:0] SRC_PC8 = 2'd2;

    localparam int MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW     = $clog2(MD_MAX + 1);

    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] src;
        logic [1:0] tnew;
    } stage_t;

    stage_t        e_q, m_q, d_entry;
    logic [4:0]    w_dst;
    logic [1:0]    w_tnew;
    logic [CW-1:0] md_cnt;
    logic [3:0]    rs_res, rt_res;
    logic          md_stall;

    function automatic logic [1:0] entry_tnew(input logic [1:0] src);
        case (src)
            SRC_ALU: return 2'd1;
            SRC_MEM: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] dec_sat(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // Returns {stall, select}; the youngest matching stage shadows older ones even when it stalls.
    function automatic logic [3:0] resolve(input logic [4:0] addr, input logic [1:0] tuse,
                                           input stage_t e, input stage_t m,
                                           input logic [4:0] wd, input logic [1:0] wt);
        logic       stall;
        logic [2:0] sel;
        stall = 1'b0;
        sel   = 3'd0;
        if (addr != 5'd0) begin
            if (e.dst == addr) begin
                stall = e.tnew > tuse;
                if (!stall && e.src == SRC_PC8) sel = 3'd1;
            end else if (m.dst == addr) begin
                stall = m.tnew > tuse;
                if (!stall) begin
                    case (m.src)
                        SRC_PC8: sel = 3'd2;
                        SRC_ALU: sel = 3'd3;
                        default: sel = 3'd0;
                    endcase
                end
            end else if (wd == addr) begin
                stall = wt > tuse;
                if (!stall) sel = 3'd4;
            end
        end
        return {stall, sel};
    endfunction

    always_comb begin
        d_entry               = {dst_d, src_d, entry_tnew(src_d)};
        rs_res                = resolve(rs_d, rs_tuse_d, e_q, m_q, w_dst, w_tnew);
        rt_res                = resolve(rt_d, rt_tuse_d, e_q, m_q, w_dst, w_tnew);
        md_busy               = md_cnt != '0;
        md_stall              = md_use_d && md_busy;
        stop                  = rs_res[3] | rt_res[3] | md_stall;
        rs_data_d_to_reg_type = rs_res[2:0];
        rt_data_d_to_reg_type = rt_res[2:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q    <= '0;
            m_q    <= '0;
            w_dst  <= '0;
            w_tnew <= '0;
            md_cnt <= '0;
        end else begin
            w_dst  <= m_q.dst;
            w_tnew <= dec_sat(m_q.tnew);
            m_q    <= {e_q.dst, e_q.src, dec_sat(e_q.tnew)};
            e_q    <= stop ? '0 : d_entry;
            if (md_start_d && !stop)
                md_cnt <= md_div_d ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            else if (md_cnt != '0)
                md_cnt <= md_cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb/tb_hazard_scheduler.sv - vector table, corner sequences and randomized reference-model bench for hazard_scheduler
module tb_hazard_scheduler;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic       clk;
    logic       reset;
    logic [4:0] rs_d, rt_d, dst_d;
    logic [1:0] rs_tuse_d, rt_tuse_d, src_d;
    logic       md_start_d, md_div_d, md_use_d;
    logic       stop, md_busy;
    logic [2:0] rs_sel, rt_sel;

    int vectors;
    int miscompares;

    hazard_scheduler #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .rs_d                  (rs_d),
        .rt_d                  (rt_d),
        .rs_tuse_d             (rs_tuse_d),
        .rt_tuse_d             (rt_tuse_d),
        .dst_d                 (dst_d),
        .src_d                 (src_d),
        .md_start_d            (md_start_d),
        .md_div_d              (md_div_d),
        .md_use_d              (md_use_d),
        .stop                  (stop),
        .rs_data_d_to_reg_type (rs_sel),
        .rt_data_d_to_reg_type (rt_sel),
        .md_busy               (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs;
        logic [1:0] rs_tuse;
        logic [4:0] rt;
        logic [1:0] rt_tuse;
        logic [4:0] dst;
        logic [1:0] src;
        logic       exp_stop;
        logic [2:0] exp_rs;
        logic [2:0] exp_rt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int rs, input int rst, input int rt, input int rtt,
                                input int dst, input int src, input int es, input int ers,
                                input int ert);
        vec_t v;
        v.rs = 5'(rs);   v.rs_tuse = 2'(rst);
        v.rt = 5'(rt);   v.rt_tuse = 2'(rtt);
        v.dst = 5'(dst); v.src = 2'(src);
        v.exp_stop = 1'(es);
        v.exp_rs = 3'(ers);
        v.exp_rt = 3'(ert);
        return v;
    endfunction

    task automatic drive(input int rs, input int rst, input int rt, input int rtt,
                         input int dst, input int src, input int ms, input int mdv, input int mu);
        rs_d = 5'(rs);   rs_tuse_d = 2'(rst);
        rt_d = 5'(rt);   rt_tuse_d = 2'(rtt);
        dst_d = 5'(dst); src_d = 2'(src);
        md_start_d = 1'(ms); md_div_d = 1'(mdv); md_use_d = 1'(mu);
    endtask

    task automatic check(input string name, input logic es, input logic [2:0] ers,
                         input logic [2:0] ert, input logic eb);
        vectors++;
        if (stop !== es || rs_sel !== ers || rt_sel !== ert || md_busy !== eb) begin
            miscompares++;
            $display("FAIL %s @%0t: stop=%b/%b rs_sel=%0d/%0d rt_sel=%0d/%0d md_busy=%b/%b (got/exp)",
                     name, $time, stop, es, rs_sel, ers, rt_sel, ert, md_busy, eb);
        end
    endtask

    task automatic do_reset();
        drive(0, 3, 0, 3, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    // Reference model: each slot remembers when its instruction entered E; remaining latency
    // is the source's base latency minus elapsed cycles, and md busy is a deadline.
    int mdst[3], msrc[3], menter[3];
    int cyc, md_done;
    logic       m_stop, m_busy;
    logic [2:0] m_rs, m_rt;

    function automatic int base_lat(input int s);
        return (s == 1) ? 2 : (s == 0) ? 1 : 0;
    endfunction

    function automatic int remaining(input int k);
        int t;
        t = base_lat(msrc[k]) - (cyc - menter[k]);
        return (t < 0) ? 0 : t;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mdst[k] = 0; msrc[k] = 0; menter[k] = 0;
        end
        cyc = 0;
        md_done = 0;
    endtask

    task automatic model_operand(input int addr, input int tuse, output logic st,
                                 output logic [2:0] sel);
        bit found;
        st = 1'b0; sel = 3'd0; found = 0;
        if (addr != 0) begin
            for (int k = 0; k < 3; k++) begin
                if (!found && mdst[k] == addr) begin
                    found = 1;
                    st = remaining(k) > tuse;
                    if (!st) begin
                        if (k == 0)      sel = (msrc[k] == 2) ? 3'd1 : 3'd0;
                        else if (k == 1) sel = (msrc[k] == 2) ? 3'd2 : (msrc[k] == 0) ? 3'd3 : 3'd0;
                        else             sel = 3'd4;
                    end
                end
            end
        end
    endtask

    task automatic model_eval();
        logic rs_st, rt_st;
        model_operand(int'(rs_d), int'(rs_tuse_d), rs_st, m_rs);
        model_operand(int'(rt_d), int'(rt_tuse_d), rt_st, m_rt);
        m_busy = cyc < md_done;
        m_stop = rs_st | rt_st | (md_use_d & m_busy);
    endtask

    task automatic model_advance();
        for (int k = 2; k > 0; k--) begin
            mdst[k] = mdst[k-1]; msrc[k] = msrc[k-1]; menter[k] = menter[k-1];
        end
        mdst[0]   = m_stop ? 0 : int'(dst_d);
        msrc[0]   = m_stop ? 0 : int'(src_d);
        menter[0] = cyc + 1;
        cyc++;
        if (md_start_d && !m_stop) md_done = cyc + (md_div_d ? DIV_N : MULT_N);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b0;
        drive(3, 0, 3, 0, 3, 1, 1, 1, 1);
        #3 check("in_reset", 1'b0, 3'd0, 3'd0, 1'b0);
        @(posedge clk);
        do_reset();

        // rs, rs_tuse, rt, rt_tuse, dst, src, stop, rs_sel, rt_sel
        tbl.push_back(mk(1, 1, 2, 1, 3, 0, 0, 0, 0));
        tbl.push_back(mk(3, 1, 0, 3, 4, 0, 0, 0, 0));
        tbl.push_back(mk(3, 0, 4, 1, 0, 0, 0, 3, 0));
        tbl.push_back(mk(3, 0, 4, 0, 0, 0, 0, 4, 3));
        tbl.push_back(mk(0, 3, 0, 3, 5, 1, 0, 0, 0));
        tbl.push_back(mk(5, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(5, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(5, 0, 0, 0, 0, 0, 0, 4, 0));
        tbl.push_back(mk(0, 3, 0, 3, 6, 1, 0, 0, 0));
        tbl.push_back(mk(6, 1, 6, 2, 0, 0, 1, 0, 0));
        tbl.push_back(mk(6, 1, 6, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3, 0, 3, 31, 2, 0, 0, 0));
        tbl.push_back(mk(31, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(31, 0, 31, 1, 0, 0, 0, 2, 2));
        tbl.push_back(mk(31, 0, 31, 1, 0, 0, 0, 4, 4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3, 0, 3, 7, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3, 0, 3, 7, 1, 0, 0, 0));
        tbl.push_back(mk(7, 0, 0, 3, 0, 0, 1, 0, 0));
        tbl.push_back(mk(7, 0, 0, 3, 0, 0, 1, 0, 0));
        tbl.push_back(mk(7, 0, 0, 3, 0, 0, 0, 4, 0));

        foreach (tbl[i]) begin
            @(posedge clk);
            #1 drive(tbl[i].rs, tbl[i].rs_tuse, tbl[i].rt, tbl[i].rt_tuse,
                     tbl[i].dst, tbl[i].src, 0, 0, 0);
            #1 check($sformatf("table[%0d]", i), tbl[i].exp_stop, tbl[i].exp_rs,
                     tbl[i].exp_rt, 1'b0);
        end

        // div then a HI/LO reader, then mult with an early and an on-time reader
        do_reset();
        @(posedge clk); #1 drive(0, 3, 0, 3, 0, 0, 1, 1, 1);
        #1 check("div_issue", 1'b0, 3'd0, 3'd0, 1'b0);
        for (int i = 0; i < DIV_N; i++) begin
            @(posedge clk); #1 drive(0, 3, 0, 3, 8, 0, 0, 0, 1);
            #1 check($sformatf("div_busy[%0d]", i), 1'b1, 3'd0, 3'd0, 1'b1);
        end
        @(posedge clk); #1 drive(0, 3, 0, 3, 8, 0, 0, 0, 1);
        #1 check("div_done", 1'b0, 3'd0, 3'd0, 1'b0);
        @(posedge clk); #1 drive(0, 3, 0, 3, 0, 0, 1, 0, 1);
        #1 check("mult_issue", 1'b0, 3'd0, 3'd0, 1'b0);
        for (int i = 0; i < MULT_N - 1; i++) begin
            @(posedge clk); #1 drive(0, 3, 0, 3, 0, 0, 0, 0, 0);
            #1 check($sformatf("mult_busy[%0d]", i), 1'b0, 3'd0, 3'd0, 1'b1);
        end
        @(posedge clk); #1 drive(0, 3, 0, 3, 9, 0, 0, 0, 1);
        #1 check("mfhi_early", 1'b1, 3'd0, 3'd0, 1'b1);
        @(posedge clk); #1 drive(0, 3, 0, 3, 9, 0, 0, 0, 1);
        #1 check("mfhi_ok", 1'b0, 3'd0, 3'd0, 1'b0);

        // reset asserted mid-stall with a live W forward
        do_reset();
        @(posedge clk); #1 drive(0, 3, 0, 3, 9, 1, 0, 0, 0);
        #1 check("rst_lw", 1'b0, 3'd0, 3'd0, 1'b0);
        @(posedge clk); #1 drive(0, 3, 0, 3, 0, 0, 1, 1, 1);
        #1 check("rst_div", 1'b0, 3'd0, 3'd0, 1'b0);
        @(posedge clk); #1 drive(9, 0, 0, 3, 0, 0, 0, 0, 1);
        #1 check("rst_stall_m", 1'b1, 3'd0, 3'd0, 1'b1);
        @(posedge clk); #1 drive(9, 0, 0, 3, 0, 0, 0, 0, 1);
        #1 check("rst_stall_w", 1'b1, 3'd4, 3'd0, 1'b1);
        #1 reset = 1'b0;
        #1 check("rst_async", 1'b0, 3'd0, 3'd0, 1'b0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check("rst_release", 1'b0, 3'd0, 3'd0, 1'b0);
        @(posedge clk); #1 drive(9, 0, 0, 3, 0, 0, 0, 0, 1);
        #1 check("rst_after", 1'b0, 3'd0, 3'd0, 1'b0);

        // randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            rs_d       = 5'($urandom_range(0, 7));
            rt_d       = 5'($urandom_range(0, 7));
            rs_tuse_d  = 2'($urandom_range(0, 3));
            rt_tuse_d  = 2'($urandom_range(0, 3));
            dst_d      = 5'($urandom_range(0, 7));
            src_d      = 2'($urandom_range(0, 2));
            md_start_d = ($urandom_range(0, 15) == 0);
            md_div_d   = 1'($urandom_range(0, 1));
            md_use_d   = md_start_d | ($urandom_range(0, 3) == 0);
            #1;
            model_eval();
            check("random", m_stop, m_rs, m_rt, m_busy);
            model_advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
